bcd_hex_display: RTL and testbench
==================================

// Module: bcd_hex_display
// PURPOSE
//   Downstream consumer of the binary-to-BCD converter output. Captures a packed BCD
//   word on a load strobe and drives DIGITS active-low 7-segment HEX displays.
//   Provides invalid-digit marking, optional leading-zero blanking, and a timed
//   blink sequence used for score/level flashes in the game UI.
// PARAMETERS
//   DIGITS     6           number of BCD digits / HEX displays driven
//   BLINK_DIV  25_000_000  clk cycles per blink half-period (>=1)
//   BLINK_CNT  3           number of off/on blink pairs per blink request (>=1)
// PORTS
//   clk        in   1            single system clock, rising edge
//   rst        in   1            synchronous, active-high reset
//   bcd_in     in   4*DIGITS     packed BCD {..., hundreds, tens, ones}; nibble d = digit d
//   load       in   1            capture bcd_in on this edge
//   blink_req  in   1            start blink sequence (ignored while busy)
//   busy       out  1            high while blink sequence active
//   hex_n      out  7*DIGITS     hex_n[7d+6:7d] = {g,f,e,d,c,b,a}, active-low, registered
// BEHAVIOUR
//   Reset: one clock, synchronous, active-high (rst). In reset: data_q=0, valid_q=0,
//     state=STEADY, counters=0, busy=0, hex_n all ones (blank). rst overrides everything.
//   Capture: load high at edge N -> data_q=bcd_in, valid_q=1 at N; hex_n shows it after N+1
//     (2-edge latency from sample). Back-to-back loads are each captured; the last one wins.
//   Display blank (all ones) until first load after reset (valid_q=0).
//   Decode per nibble: 0-9 standard font (0=1000000, 1=1111001, 2=0100100, 3=0110000,
//     5=0010010, 8=0000000); A-F -> dash 0111111; blank=1111111.
//   FSM states STEADY, BLINK_OFF, BLINK_ON:
//     STEADY: busy=0; blink_req -> BLINK_OFF, half_cnt=BLINK_DIV-1, pair_cnt=BLINK_CNT-1.
//     BLINK_OFF: all digits blank; half_cnt counts down; at 0 -> BLINK_ON, reload half_cnt.
//     BLINK_ON: decoded value shown; at half_cnt 0: pair_cnt==0 -> STEADY, else
//       decrement pair_cnt -> BLINK_OFF, reload.
//     busy=1 in BLINK_OFF/BLINK_ON; total busy = 2*BLINK_CNT*BLINK_DIV cycles.
//   blink_req while busy: ignored (no restart, no queueing).
//   load during blink: captured normally; sequence timing unaffected; new value in ON phases.
//   load and blink_req on same edge in STEADY: both honoured; the new value blinks.
//   Counter widths: $clog2(BLINK_DIV+1), $clog2(BLINK_CNT+1); no wrap beyond reload.
// CONFIGURATION
//   BCD_HEX_DISPLAY_LZB_EN defined: leading-zero blanking. Digits above the most
//     significant non-zero nibble are blank; digit 0 is always shown, so value 0 shows "0".
//     Invalid nibbles (A-F) count as non-zero.
//   Not defined: every digit is decoded, including leading zeros.
// TESTING  (DIGITS=6, BLINK_DIV=4, BLINK_CNT=2)
//   1. rst high 2 edges, then low -> hex_n=42'h3FF_FFFF_FFFF, busy=0.
//   2. load bcd_in=24'h000123 -> two edges later digit0=0110000, digit1=0100100,
//      digit2=1111001. Digits 3-5 are blank with LZB_EN; without it they are 1000000.
//   3. load 24'h000000 -> digit0=1000000; digits 1-5 blank (LZB_EN).
//   4. load 24'h0000A7 -> digit1=0111111 dash, digit0='7'=1111000; digit1 is not blanked.
//   5. blink_req pulse after a load -> busy=1 for exactly 16 cycles; blank cycles 1-4 and 9-12,
//      value shown in cycles 5-8 and 13-16; a second blink_req mid-sequence has no effect.
//   6. rst asserted in BLINK_OFF -> next edge busy=0, hex_n all ones; a later load shows normally.

Source files
------------

// File: rtl/bcd_hex_display.sv
// ============================================================================
// Module      : bcd_hex_display
// Description : Captures a packed BCD word and drives active-low 7-segment
//               HEX displays, with dash marking of invalid nibbles and a
//               timed blink sequence. Optional leading-zero blanking is
//               enabled by defining BCD_HEX_DISPLAY_LZB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_hex_display #(
    parameter int DIGITS    = 6,
    parameter int BLINK_DIV = 25_000_000,
    parameter int BLINK_CNT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  load,
    input  logic                  blink_req,
    output logic                  busy,
    output logic [7*DIGITS-1:0]   hex_n
);

    localparam int HALF_W = $clog2(BLINK_DIV + 1);
    localparam int PAIR_W = $clog2(BLINK_CNT + 1);
    localparam logic [HALF_W-1:0] C_HALF_RELOAD = HALF_W'(BLINK_DIV - 1);
    localparam logic [PAIR_W-1:0] C_PAIR_RELOAD = PAIR_W'(BLINK_CNT - 1);
    localparam logic [6:0]        C_SEG_BLANK   = 7'b1111111;

    typedef enum logic [1:0] {
        ST_STEADY    = 2'd0,
        ST_BLINK_OFF = 2'd1,
        ST_BLINK_ON  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [HALF_W-1:0]     r_half_cnt;
    logic [HALF_W-1:0]     w_half_cnt_next;
    logic [PAIR_W-1:0]     r_pair_cnt;
    logic [PAIR_W-1:0]     w_pair_cnt_next;
    logic [4*DIGITS-1:0]   r_data;
    logic                  r_valid;
    logic [7*DIGITS-1:0]   r_hex_n;
    logic [7*DIGITS-1:0]   w_seg;
    logic [DIGITS-1:0]     w_blank_digit;

    // Font bit order is {g,f,e,d,c,b,a}; non-BCD nibbles render as a dash.
    function automatic logic [6:0] f_seg(input logic [3:0] i_nib);
        case (i_nib)
            4'd0:    f_seg = 7'b1000000;
            4'd1:    f_seg = 7'b1111001;
            4'd2:    f_seg = 7'b0100100;
            4'd3:    f_seg = 7'b0110000;
            4'd4:    f_seg = 7'b0011001;
            4'd5:    f_seg = 7'b0010010;
            4'd6:    f_seg = 7'b0000010;
            4'd7:    f_seg = 7'b1111000;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0010000;
            default: f_seg = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        w_state_next    = r_state;
        w_half_cnt_next = r_half_cnt;
        w_pair_cnt_next = r_pair_cnt;
        case (r_state)
            ST_STEADY: begin
                if (blink_req) begin
                    w_state_next    = ST_BLINK_OFF;
                    w_half_cnt_next = C_HALF_RELOAD;
                    w_pair_cnt_next = C_PAIR_RELOAD;
                end
            end
            ST_BLINK_OFF: begin
                if (r_half_cnt == '0) begin
                    w_state_next    = ST_BLINK_ON;
                    w_half_cnt_next = C_HALF_RELOAD;
                end else begin
                    w_half_cnt_next = r_half_cnt - 1'b1;
                end
            end
            ST_BLINK_ON: begin
                if (r_half_cnt == '0) begin
                    if (r_pair_cnt == '0) begin
                        w_state_next = ST_STEADY;
                    end else begin
                        w_state_next    = ST_BLINK_OFF;
                        w_pair_cnt_next = r_pair_cnt - 1'b1;
                        w_half_cnt_next = C_HALF_RELOAD;
                    end
                end else begin
                    w_half_cnt_next = r_half_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next = ST_STEADY;
            end
        endcase
    end

`ifdef BCD_HEX_DISPLAY_LZB_EN
    // w_zero_above[d] is set when digits d..DIGITS-1 are all zero.
    logic [DIGITS:1] w_zero_above;
    assign w_zero_above[DIGITS] = 1'b1;
    assign w_blank_digit[0]     = 1'b0;
    for (genvar d = 1; d < DIGITS; d++) begin : g_lzb
        assign w_zero_above[d]  = w_zero_above[d+1] && (r_data[4*d +: 4] == 4'd0);
        assign w_blank_digit[d] = w_zero_above[d];
    end
`else
    assign w_blank_digit = '0;
`endif

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        assign w_seg[7*d +: 7] = w_blank_digit[d] ? C_SEG_BLANK : f_seg(r_data[4*d +: 4]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_STEADY;
            r_half_cnt <= '0;
            r_pair_cnt <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_hex_n    <= '1;
        end else begin
            r_state    <= w_state_next;
            r_half_cnt <= w_half_cnt_next;
            r_pair_cnt <= w_pair_cnt_next;
            if (load) begin
                r_data  <= bcd_in;
                r_valid <= 1'b1;
            end
            // Blanking follows the next state so the dark phase lines up with busy.
            if (!r_valid || w_state_next == ST_BLINK_OFF) begin
                r_hex_n <= '1;
            end else begin
                r_hex_n <= w_seg;
            end
        end
    end

    assign busy  = (r_state != ST_STEADY);
    assign hex_n = r_hex_n;

endmodule

`default_nettype wire

// File: tb/tb_bcd_hex_display.sv
// ============================================================================
// Module      : tb_bcd_hex_display
// Description : Randomized self-checking bench for bcd_hex_display against a
//               cycle-level behavioural model of the display contents.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_hex_display;

    localparam int DIGITS = 6;
    localparam int DIV    = 4;
    localparam int CNT    = 2;
    localparam int TOTAL  = 2 * CNT * DIV;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [4*DIGITS-1:0]  bcd_in;
    logic                 load;
    logic                 blink_req;
    logic                 busy;
    logic [7*DIGITS-1:0]  hex_n;

    int checks = 0;
    int errors = 0;

    logic [4*DIGITS-1:0]  m_data;
    logic                 m_valid;
    int                   m_left;
    logic [7*DIGITS-1:0]  m_hex;

    logic [6:0] font [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};

    bcd_hex_display #(
        .DIGITS    (DIGITS),
        .BLINK_DIV (DIV),
        .BLINK_CNT (CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bcd_in    (bcd_in),
        .load      (load),
        .blink_req (blink_req),
        .busy      (busy),
        .hex_n     (hex_n)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7*DIGITS-1:0] render(input logic [4*DIGITS-1:0] v);
        logic [7*DIGITS-1:0] r;
        logic [3:0]          nib;
        r = '1;
        for (int d = 0; d < DIGITS; d++) begin
            nib = v[4*d +: 4];
`ifdef BCD_HEX_DISPLAY_LZB_EN
            if (d != 0 && (v >> (4*d)) == 0) continue;
`endif
            r[7*d +: 7] = (nib <= 4'd9) ? font[nib] : 7'b0111111;
        end
        return r;
    endfunction

    // One clock: apply inputs, advance the model, then compare away from the edge.
    task automatic tick(input logic r, input logic ld, input logic br, input logic [4*DIGITS-1:0] val);
        logic                old_valid;
        logic [4*DIGITS-1:0] old_data;
        bit                  dark;
        rst = r; load = ld; blink_req = br; bcd_in = val;
        @(posedge clk);
        if (r) begin
            m_data = '0; m_valid = 1'b0; m_left = 0; m_hex = '1;
        end else begin
            old_valid = m_valid;
            old_data  = m_data;
            if (m_left > 0) m_left--;
            else if (br)    m_left = TOTAL;
            dark  = (m_left > 0) && ((((TOTAL - m_left) / DIV) % 2) == 0);
            m_hex = (!old_valid || dark) ? '1 : render(old_data);
            if (ld) begin
                m_data  = val;
                m_valid = 1'b1;
            end
        end
        #1;
        check_val("hex_n", 64'(hex_n), 64'(m_hex));
        check_val("busy", 64'(busy), 64'(m_left > 0));
    endtask

    function automatic logic [4*DIGITS-1:0] rand_bcd();
        logic [4*DIGITS-1:0] v;
        int                  n;
        v = '0;
        n = $urandom_range(0, DIGITS);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
            else                           v[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    initial begin
        int busy_cycles;
        rst = 1'b1; load = 1'b0; blink_req = 1'b0; bcd_in = '0;
        m_data = '0; m_valid = 1'b0; m_left = 0; m_hex = '1;

        tick(1, 0, 0, '0);
        tick(1, 0, 0, '0);
        check_val("reset_hex", 64'(hex_n), 64'h3FF_FFFF_FFFF);
        check_val("reset_busy", 64'(busy), 64'd0);
        tick(0, 0, 0, '0);
        check_val("blank_before_load", 64'(hex_n), 64'h3FF_FFFF_FFFF);

        tick(0, 1, 0, 24'h000123);
        tick(0, 0, 0, '0);
        check_val("d0_of_123", 64'(hex_n[6:0]),   64'(7'b0110000));
        check_val("d1_of_123", 64'(hex_n[13:7]),  64'(7'b0100100));
        check_val("d2_of_123", 64'(hex_n[20:14]), 64'(7'b1111001));
`ifdef BCD_HEX_DISPLAY_LZB_EN
        check_val("d3_of_123", 64'(hex_n[27:21]), 64'(7'b1111111));
`else
        check_val("d3_of_123", 64'(hex_n[27:21]), 64'(7'b1000000));
`endif

        tick(0, 1, 0, 24'h000000);
        tick(0, 0, 0, '0);
        check_val("d0_of_zero", 64'(hex_n[6:0]), 64'(7'b1000000));

        tick(0, 1, 0, 24'h0000A7);
        tick(0, 0, 0, '0);
        check_val("d0_of_A7", 64'(hex_n[6:0]),  64'(7'b1111000));
        check_val("d1_of_A7", 64'(hex_n[13:7]), 64'(7'b0111111));

        // Blink with a redundant request mid-sequence.
        busy_cycles = 0;
        tick(0, 0, 1, '0);
        if (busy) busy_cycles++;
        for (int i = 1; i < TOTAL + 4; i++) begin
            tick(0, 0, (i == 6), '0);
            if (busy) busy_cycles++;
        end
        check_val("busy_length", 64'(busy_cycles), 64'(TOTAL));

        // Reset while dark, then a fresh load.
        tick(0, 0, 1, '0);
        tick(0, 0, 0, '0);
        tick(1, 0, 0, '0);
        check_val("rst_in_blink_busy", 64'(busy), 64'd0);
        check_val("rst_in_blink_hex", 64'(hex_n), 64'h3FF_FFFF_FFFF);
        tick(0, 1, 0, 24'h000456);
        tick(0, 0, 0, '0);

        // Simultaneous load and blink request.
        tick(0, 1, 1, 24'h000789);
        for (int i = 0; i < TOTAL + 2; i++) tick(0, 0, 0, '0);

        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 15) == 0),
                 rand_bcd());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
